uart_imem_loader: RTL and testbench

//   Boot-loader stage directly downstream of the UART receiver. It consumes each 32-bit word the receiver

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/uart_imem_loader.sv | 131 +++++++++++++
 tb/tb_uart_imem_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared widths and loader state encoding for the UART boot path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 32;
  localparam int UART_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det : registered rising-edge detector, one pulse per high period
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b1;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/uart_imem_loader.sv
// ---------------------------------------------------------------------------
// uart_imem_loader : parses [N][N words][checksum] from the UART receiver,
//                    writes imem and releases the CPU on a good checksum
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_imem_loader
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int ADDR_W  = UART_ADDR_W,
  parameter int IMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_done,
  input  logic [DATA_W-1:0]  buffer,
  input  logic [ADDR_W-1:0]  data_addr,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst_n,
  output logic               load_busy,
  output logic               load_ok,
  output logic               load_err,
  output logic [IMEM_AW:0]   words_loaded
);

  localparam logic [DATA_W-1:0] CAPACITY = DATA_W'(2 ** IMEM_AW);

  loader_state_t      state, next_state;
  logic               evt;
  logic [IMEM_AW:0]   n_words;
  logic [IMEM_AW:0]   cnt;
  logic [IMEM_AW:0]   cnt_inc;
  logic [DATA_W-1:0]  sum;
  logic [ADDR_W-1:0]  exp_addr;
  logic               addr_ok;
  logic               do_write;
  logic               hdr_accept;

  sync_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_done),
    .rise  (evt)
  );

  assign cnt_inc = cnt + (IMEM_AW + 1)'(1);

  // Ordinal expected for the next word: header is 0, program word k is k+1,
  // checksum is N+1.
  always_comb begin
    exp_addr = '0;
    case (state)
      ST_LOAD:  exp_addr = ADDR_W'(cnt) + ADDR_W'(1);
      ST_CHECK: exp_addr = ADDR_W'(n_words) + ADDR_W'(1);
      default:  exp_addr = '0;
    endcase
  end

  assign addr_ok = (data_addr == exp_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Ordinal mismatch is tested first in every state so it dominates.
  always_comb begin
    next_state = state;
    if (evt) begin
      case (state)
        ST_IDLE: begin
          if (!addr_ok)                next_state = ST_ERR;
          else if (buffer > CAPACITY)  next_state = ST_ERR;
          else if (buffer == '0)       next_state = ST_CHECK;
          else                         next_state = ST_LOAD;
        end
        ST_LOAD: begin
          if (!addr_ok)                next_state = ST_ERR;
          else if (cnt_inc == n_words) next_state = ST_CHECK;
        end
        ST_CHECK: begin
          if (addr_ok && buffer == sum) next_state = ST_RUN;
          else                          next_state = ST_ERR;
        end
        default: next_state = state;
      endcase
    end
  end

  assign do_write   = evt && (state == ST_LOAD) && addr_ok;
  assign hdr_accept = evt && (state == ST_IDLE) && (next_state != ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      n_words    <= '0;
      cnt        <= '0;
      sum        <= '0;
      cpu_rst_n  <= 1'b0;
      load_busy  <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= do_write;
      if (do_write) begin
        imem_addr  <= cnt[IMEM_AW-1:0];
        imem_wdata <= buffer;
        sum        <= sum + buffer;
        cnt        <= cnt_inc;
      end
      if (hdr_accept) begin
        n_words <= buffer[IMEM_AW:0];
      end
      load_busy <= (next_state == ST_LOAD) || (next_state == ST_CHECK);
      load_ok   <= (next_state == ST_RUN);
      cpu_rst_n <= (next_state == ST_RUN);
      load_err  <= (next_state == ST_ERR);
    end
  end

  assign words_loaded = cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_imem_loader : table-driven frame vectors plus a reset-release case
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_done = 1'b0;
  logic [31:0] buffer = '0;
  logic [15:0] data_addr = '0;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        load_busy;
  logic        load_ok;
  logic        load_err;
  logic [12:0] words_loaded;

  uart_imem_loader #(.DATA_W(32), .ADDR_W(16), .IMEM_AW(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_done    (uart_done),
    .buffer       (buffer),
    .data_addr    (data_addr),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .load_busy    (load_busy),
    .load_ok      (load_ok),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int wr_cnt = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) if (imem_we === 1'b1) wr_cnt = wr_cnt + 1;

  typedef struct {
    bit          rst;
    logic [31:0] data;
    logic [15:0] addr;
    int          hold;
    int          dw;
    bit          busy, ok, err, cpu;
    int          words;
    bit          chk_w;
    logic [11:0] waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic w(input logic [31:0] d, input logic [15:0] a, input int h, input int dw,
                   input bit busy, input bit ok, input bit err, input bit cpu, input int words,
                   input bit chkw, input logic [11:0] wa, input logic [31:0] wd);
    vec_t v;
    v.rst = 1'b0; v.data = d; v.addr = a; v.hold = h; v.dw = dw;
    v.busy = busy; v.ok = ok; v.err = err; v.cpu = cpu; v.words = words;
    v.chk_w = chkw; v.waddr = wa; v.wdata = wd;
    vecs.push_back(v);
  endtask

  task automatic r();
    vec_t v;
    v.rst = 1'b1; v.data = '0; v.addr = '0; v.hold = 0; v.dw = 0;
    v.busy = 0; v.ok = 0; v.err = 0; v.cpu = 0; v.words = 0;
    v.chk_w = 1'b1; v.waddr = '0; v.wdata = '0;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_cnt;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [15:0] a, input int h);
    @(negedge clk);
    uart_done = 1'b1;
    buffer    = d;
    data_addr = a;
    repeat (h) @(negedge clk);
    uart_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, " writes"},    wr_cnt - base, v.dw);
    chk({p, " load_busy"}, {31'b0, load_busy}, {31'b0, v.busy});
    chk({p, " load_ok"},   {31'b0, load_ok},   {31'b0, v.ok});
    chk({p, " load_err"},  {31'b0, load_err},  {31'b0, v.err});
    chk({p, " cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, v.cpu});
    chk({p, " words_loaded"}, {19'b0, words_loaded}, v.words);
    if (v.chk_w) begin
      chk({p, " imem_addr"},  {20'b0, imem_addr}, {20'b0, v.waddr});
      chk({p, " imem_wdata"}, imem_wdata, v.wdata);
      chk({p, " imem_we"},    {31'b0, imem_we}, 32'd0);
    end
  endtask

  initial begin
    // Good frame, done held 5 cycles per word, then stray events in RUN.
    r();
    w(32'd3,         16'd0, 5, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'h00000013,  16'd1, 5, 1, 1, 0, 0, 0, 1, 1, 12'd0, 32'h00000013);
    w(32'h00100093,  16'd2, 5, 2, 1, 0, 0, 0, 2, 1, 12'd1, 32'h00100093);
    w(32'h00000063,  16'd3, 5, 3, 1, 0, 0, 0, 3, 1, 12'd2, 32'h00000063);
    w(32'h00100109,  16'd4, 5, 3, 0, 1, 0, 1, 3, 1, 12'd2, 32'h00000063);
    w(32'h0000dead,  16'd5, 5, 3, 0, 1, 0, 1, 3, 1, 12'd2, 32'h00000063);
    w(32'h00000000,  16'd0, 5, 3, 0, 1, 0, 1, 3, 0, 12'd0, 32'h0);
    // Bad checksum.
    r();
    w(32'd3,         16'd0, 1, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'h00000013,  16'd1, 1, 1, 1, 0, 0, 0, 1, 0, 12'd0, 32'h0);
    w(32'h00100093,  16'd2, 1, 2, 1, 0, 0, 0, 2, 0, 12'd0, 32'h0);
    w(32'h00000063,  16'd3, 1, 3, 1, 0, 0, 0, 3, 0, 12'd0, 32'h0);
    w(32'h00100108,  16'd4, 1, 3, 0, 0, 1, 0, 3, 1, 12'd2, 32'h00000063);
    // Empty program.
    r();
    w(32'd0,         16'd0, 1, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'd0,         16'd1, 1, 0, 0, 1, 0, 1, 0, 1, 12'd0, 32'h0);
    // Empty program, checksum value right but ordinal wrong.
    r();
    w(32'd0,         16'd0, 1, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'd0,         16'd2, 1, 0, 0, 0, 1, 0, 0, 1, 12'd0, 32'h0);
    // Header one past capacity, then exactly at capacity.
    r();
    w(32'h00001001,  16'd0, 1, 0, 0, 0, 1, 0, 0, 1, 12'd0, 32'h0);
    r();
    w(32'h00001000,  16'd0, 1, 0, 1, 0, 0, 0, 0, 1, 12'd0, 32'h0);
    // Header with non-zero ordinal.
    r();
    w(32'd3,         16'd1, 1, 0, 0, 0, 1, 0, 0, 1, 12'd0, 32'h0);
    // Second program word with skipped ordinal.
    r();
    w(32'd3,         16'd0, 1, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'h00000013,  16'd1, 1, 1, 1, 0, 0, 0, 1, 1, 12'd0, 32'h00000013);
    w(32'h00100093,  16'd3, 1, 1, 0, 0, 1, 0, 1, 1, 12'd0, 32'h00000013);
    w(32'h00000063,  16'd2, 1, 1, 0, 0, 1, 0, 1, 1, 12'd0, 32'h00000013);
    // Reset mid-frame, then a full frame.
    r();
    w(32'd3,         16'd0, 2, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'h00000013,  16'd1, 2, 1, 1, 0, 0, 0, 1, 1, 12'd0, 32'h00000013);
    r();
    w(32'd3,         16'd0, 2, 0, 1, 0, 0, 0, 0, 0, 12'd0, 32'h0);
    w(32'h00000013,  16'd1, 2, 1, 1, 0, 0, 0, 1, 0, 12'd0, 32'h0);
    w(32'h00100093,  16'd2, 2, 2, 1, 0, 0, 0, 2, 0, 12'd0, 32'h0);
    w(32'h00000063,  16'd3, 2, 3, 1, 0, 0, 0, 3, 0, 12'd0, 32'h0);
    w(32'h00100109,  16'd4, 2, 3, 0, 1, 0, 1, 3, 1, 12'd2, 32'h00000063);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else             send_word(vecs[i].data, vecs[i].addr, vecs[i].hold);
      check_outputs(vecs[i], i);
    end

    // uart_done already high when reset releases must not count as a header.
    @(negedge clk);
    rst_n     = 1'b0;
    uart_done = 1'b1;
    buffer    = 32'd3;
    data_addr = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    base = wr_cnt;
    chk("held_done busy", {31'b0, load_busy}, 32'd0);
    chk("held_done err",  {31'b0, load_err},  32'd0);
    uart_done = 1'b0;
    repeat (2) @(negedge clk);
    send_word(32'd3, 16'd0, 1);
    chk("held_done header busy", {31'b0, load_busy}, 32'd1);
    send_word(32'h00000013, 16'd1, 1);
    chk("held_done first write", wr_cnt - base, 32'd1);
    chk("held_done first addr", {20'b0, imem_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
